// File: rtl/bp_pkg.sv
// Shared definitions for the direction predictor.
// Purpose: counter reset/saturation values as functions of the counter
//   width, and the table index hash used for both lookup and training.
// No ports (package).
package bp_pkg;

  // Weakly not-taken: the largest value whose MSB is still 0.
  // A 1-bit counter therefore starts at 0.
  function automatic int ctr_init(input int ctr_w);
    return (1 << (ctr_w - 1)) - 1;
  endfunction

  function automatic int ctr_max(input int ctr_w);
    return (1 << ctr_w) - 1;
  endfunction

  function automatic int ctr_min(input int ctr_w);
    return (ctr_w > 0) ? 0 : 0;
  endfunction

  // The history argument arrives zero-extended, so it only disturbs the
  // low HIST_W bits of the PC index. The caller truncates to IDX_W.
  function automatic logic [31:0] idx_hash(input logic [31:0] pc_bits,
                                           input logic [31:0] hist,
                                           input logic        gshare);
    return gshare ? (pc_bits ^ hist) : pc_bits;
  endfunction

endpackage

// File: rtl/gshare_predictor_if.sv
// Predict/update bundle between fetch, resolve and the predictor.
// master: fetch/resolve side (drives requests and updates)
// slave : predictor side (drives prediction results and current history)
//   pred_req, pred_index                       request a prediction
//   pred_valid, pred_taken, pred_ghr           registered prediction result
//   upd_valid, upd_index, upd_ghr, upd_taken,
//   upd_mispredict                             resolved-branch training
//   ghr                                        current speculative history
interface gshare_predictor_if #(
  parameter int IDX_W  = 6,
  parameter int HIST_W = 6
);
  logic              pred_req;
  logic [IDX_W-1:0]  pred_index;
  logic              pred_valid;
  logic              pred_taken;
  logic [HIST_W-1:0] pred_ghr;
  logic              upd_valid;
  logic [IDX_W-1:0]  upd_index;
  logic [HIST_W-1:0] upd_ghr;
  logic              upd_taken;
  logic              upd_mispredict;
  logic [HIST_W-1:0] ghr;

  modport master (
    output pred_req, pred_index,
    output upd_valid, upd_index, upd_ghr, upd_taken, upd_mispredict,
    input  pred_valid, pred_taken, pred_ghr, ghr
  );

  modport slave (
    input  pred_req, pred_index,
    input  upd_valid, upd_index, upd_ghr, upd_taken, upd_mispredict,
    output pred_valid, pred_taken, pred_ghr, ghr
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up/down counter, one per predictor table entry.
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset to the weakly not-taken value
//   i_inc  count up (stops at all-ones)
//   i_dec  count down (stops at zero); ignored when i_inc is set
//   o_ctr  current counter value
module sat_counter
  import bp_pkg::*;
#(
  parameter int CTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CTR_W-1:0] o_ctr
);

  localparam logic [CTR_W-1:0] C_INIT = CTR_W'(ctr_init(CTR_W));
  localparam logic [CTR_W-1:0] C_MAX  = CTR_W'(ctr_max(CTR_W));
  localparam logic [CTR_W-1:0] C_MIN  = CTR_W'(ctr_min(CTR_W));

  logic [CTR_W-1:0] r_ctr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctr <= C_INIT;
    end else if (i_inc) begin
      if (r_ctr != C_MAX) r_ctr <= r_ctr + CTR_W'(1);
    end else if (i_dec) begin
      if (r_ctr != C_MIN) r_ctr <= r_ctr - CTR_W'(1);
    end
  end

  assign o_ctr = r_ctr;

endmodule

// File: rtl/gshare_predictor.sv
// Branch direction predictor: 2**IDX_W saturating counters indexed either
// by PC bits (MODE=0) or PC bits XOR global history (MODE=1).
// History is shifted speculatively with each prediction and restored from
// the returned snapshot when the resolve stage reports a mispredict.
// Ports:
//   clk    clock, rising edge
//   reset  asynchronous active-low reset
//   bp     predict/update bundle (slave side), see gshare_predictor_if
module gshare_predictor
  import bp_pkg::*;
#(
  parameter int IDX_W  = 6,
  parameter int CTR_W  = 2,
  parameter int HIST_W = 6,
  parameter int MODE   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  gshare_predictor_if.slave    bp
);

  localparam int   DEPTH  = 1 << IDX_W;
  localparam logic GSHARE = (MODE == 1);

  logic [HIST_W-1:0] r_ghr;
  logic              r_pred_valid;
  logic              r_pred_taken;
  logic [HIST_W-1:0] r_pred_ghr;

  logic [IDX_W-1:0]  w_ri;
  logic [IDX_W-1:0]  w_wi;
  logic [DEPTH-1:0]  w_wr_sel;
  logic [CTR_W-1:0]  w_ctr [DEPTH];
  logic              w_rd_taken;
  logic [HIST_W-1:0] w_ghr_spec;
  logic [HIST_W-1:0] w_ghr_rec;
  logic [HIST_W-1:0] w_ghr_nxt;

  // Lookup uses the live speculative history; training uses the snapshot
  // that travelled down the pipe with the branch.
  assign w_ri = IDX_W'(idx_hash(32'(bp.pred_index), 32'(r_ghr), GSHARE));
  assign w_wi = IDX_W'(idx_hash(32'(bp.upd_index), 32'(bp.upd_ghr), GSHARE));

  assign w_wr_sel = bp.upd_valid ? (DEPTH'(1) << w_wi) : '0;

  for (genvar g = 0; g < DEPTH; g++) begin : g_tbl
    sat_counter #(.CTR_W(CTR_W)) u_ctr (
      .clk   (clk),
      .rst_n (reset),
      .i_inc (w_wr_sel[g] &  bp.upd_taken),
      .i_dec (w_wr_sel[g] & ~bp.upd_taken),
      .o_ctr (w_ctr[g])
    );
  end

  // Counters only change on the clock edge, so a same-cycle update to the
  // entry being read is naturally invisible here (read-before-write).
  assign w_rd_taken = w_ctr[w_ri][CTR_W-1];

  if (HIST_W == 1) begin : g_hist1
    assign w_ghr_spec = w_rd_taken;
    assign w_ghr_rec  = bp.upd_taken;
  end else begin : g_histn
    assign w_ghr_spec = {r_ghr[HIST_W-2:0], w_rd_taken};
    assign w_ghr_rec  = {bp.upd_ghr[HIST_W-2:0], bp.upd_taken};
  end

  // Recovery beats the speculative shift: the prediction made this cycle
  // sits on the wrong path and is flushed downstream.
  always_comb begin
    w_ghr_nxt = r_ghr;
    if (bp.upd_valid && bp.upd_mispredict) begin
      w_ghr_nxt = w_ghr_rec;
    end else if (bp.pred_req) begin
      w_ghr_nxt = w_ghr_spec;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ghr        <= '0;
      r_pred_valid <= 1'b0;
      r_pred_taken <= 1'b0;
      r_pred_ghr   <= '0;
    end else begin
      r_ghr        <= w_ghr_nxt;
      r_pred_valid <= bp.pred_req;
      if (bp.pred_req) begin
        r_pred_taken <= w_rd_taken;
        r_pred_ghr   <= r_ghr;
      end
    end
  end

  assign bp.pred_valid = r_pred_valid;
  assign bp.pred_taken = r_pred_taken;
  assign bp.pred_ghr   = r_pred_ghr;
  assign bp.ghr        = r_ghr;

endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor.
// Three instances: bimodal defaults, gshare defaults, and a narrow gshare
// configuration (IDX_W=4, CTR_W=1, HIST_W=1). Every cycle all outputs are
// compared with a behavioural model; directed sequences add hand-derived
// expected values for the corner cases.
module tb_gshare_predictor;

  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  gshare_predictor_if #(.IDX_W(6), .HIST_W(6)) b0 ();
  gshare_predictor_if #(.IDX_W(6), .HIST_W(6)) b1 ();
  gshare_predictor_if #(.IDX_W(4), .HIST_W(1)) b2 ();

  gshare_predictor #(.IDX_W(6), .CTR_W(2), .HIST_W(6), .MODE(0)) dut0 (
    .clk(clk), .reset(reset), .bp(b0));
  gshare_predictor #(.IDX_W(6), .CTR_W(2), .HIST_W(6), .MODE(1)) dut1 (
    .clk(clk), .reset(reset), .bp(b1));
  gshare_predictor #(.IDX_W(4), .CTR_W(1), .HIST_W(1), .MODE(1)) dut2 (
    .clk(clk), .reset(reset), .bp(b2));

  int cfg_iw [3];
  int cfg_cw [3];
  int cfg_hw [3];
  int cfg_md [3];

  int in_req [3];
  int in_pidx[3];
  int in_uv  [3];
  int in_uidx[3];
  int in_ughr[3];
  int in_ut  [3];
  int in_mis [3];

  int m_ctr [3][64];
  int m_ghr [3];
  int m_pv  [3];
  int m_pt  [3];
  int m_pg  [3];

  int n_chk;
  int n_err;

  typedef struct {
    int req;
    int pidx;
    int uv;
    int uidx;
    int ut;
    int e_pv;
    int e_pt;
    int e_ghr;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_in();
    for (int d = 0; d < 3; d++) begin
      in_req[d] = 0; in_pidx[d] = 0; in_uv[d] = 0; in_uidx[d] = 0;
      in_ughr[d] = 0; in_ut[d] = 0; in_mis[d] = 0;
    end
  endtask

  task automatic apply(input int d);
    case (d)
      0: begin
        b0.pred_req = 1'(in_req[0]);      b0.pred_index = 6'(in_pidx[0]);
        b0.upd_valid = 1'(in_uv[0]);      b0.upd_index = 6'(in_uidx[0]);
        b0.upd_ghr = 6'(in_ughr[0]);      b0.upd_taken = 1'(in_ut[0]);
        b0.upd_mispredict = 1'(in_mis[0]);
      end
      1: begin
        b1.pred_req = 1'(in_req[1]);      b1.pred_index = 6'(in_pidx[1]);
        b1.upd_valid = 1'(in_uv[1]);      b1.upd_index = 6'(in_uidx[1]);
        b1.upd_ghr = 6'(in_ughr[1]);      b1.upd_taken = 1'(in_ut[1]);
        b1.upd_mispredict = 1'(in_mis[1]);
      end
      default: begin
        b2.pred_req = 1'(in_req[2]);      b2.pred_index = 4'(in_pidx[2]);
        b2.upd_valid = 1'(in_uv[2]);      b2.upd_index = 4'(in_uidx[2]);
        b2.upd_ghr = 1'(in_ughr[2]);      b2.upd_taken = 1'(in_ut[2]);
        b2.upd_mispredict = 1'(in_mis[2]);
      end
    endcase
  endtask

  task automatic get_out(input int d, output int pv, output int pt,
                         output int pg, output int g);
    case (d)
      0: begin pv = b0.pred_valid; pt = b0.pred_taken; pg = b0.pred_ghr; g = b0.ghr; end
      1: begin pv = b1.pred_valid; pt = b1.pred_taken; pg = b1.pred_ghr; g = b1.ghr; end
      default: begin pv = b2.pred_valid; pt = b2.pred_taken; pg = b2.pred_ghr; g = b2.ghr; end
    endcase
  endtask

  task automatic model_reset(input int d);
    for (int i = 0; i < 64; i++) m_ctr[d][i] = (1 << (cfg_cw[d] - 1)) - 1;
    m_ghr[d] = 0; m_pv[d] = 0; m_pt[d] = 0; m_pg[d] = 0;
  endtask

  // One clock edge of predictor behaviour, written from the rules:
  // read old counter, train, then move history.
  task automatic model_step(input int d);
    int imask, hmask, cmax, half, ri, wi, bit_p, g0;
    imask = (1 << cfg_iw[d]) - 1;
    hmask = (1 << cfg_hw[d]) - 1;
    cmax  = (1 << cfg_cw[d]) - 1;
    half  = 1 << (cfg_cw[d] - 1);
    g0    = m_ghr[d];
    ri = (cfg_md[d] == 1) ? ((in_pidx[d] ^ g0) & imask) : (in_pidx[d] & imask);
    wi = (cfg_md[d] == 1) ? ((in_uidx[d] ^ in_ughr[d]) & imask) : (in_uidx[d] & imask);
    bit_p = (m_ctr[d][ri] >= half) ? 1 : 0;
    if (in_req[d] != 0) begin
      m_pv[d] = 1; m_pt[d] = bit_p; m_pg[d] = g0;
    end else begin
      m_pv[d] = 0;
    end
    if (in_uv[d] != 0) begin
      if (in_ut[d] != 0) begin
        if (m_ctr[d][wi] < cmax) m_ctr[d][wi] = m_ctr[d][wi] + 1;
      end else begin
        if (m_ctr[d][wi] > 0) m_ctr[d][wi] = m_ctr[d][wi] - 1;
      end
    end
    if (in_uv[d] != 0 && in_mis[d] != 0)
      m_ghr[d] = ((in_ughr[d] << 1) | in_ut[d]) & hmask;
    else if (in_req[d] != 0)
      m_ghr[d] = ((g0 << 1) | bit_p) & hmask;
  endtask

  task automatic step();
    int pv, pt, pg, g;
    for (int d = 0; d < 3; d++) apply(d);
    @(posedge clk);
    for (int d = 0; d < 3; d++) model_step(d);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      get_out(d, pv, pt, pg, g);
      chk($sformatf("d%0d_pred_valid", d), pv, m_pv[d]);
      chk($sformatf("d%0d_pred_taken", d), pt, m_pt[d]);
      chk($sformatf("d%0d_pred_ghr", d), pg, m_pg[d]);
      chk($sformatf("d%0d_ghr", d), g, m_ghr[d]);
    end
  endtask

  // Assert reset mid-cycle and confirm the outputs clear without a clock.
  task automatic do_reset(input bit check);
    int pv, pt, pg, g;
    #2;
    clear_in();
    for (int d = 0; d < 3; d++) apply(d);
    reset = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      model_reset(d);
      if (check) begin
        get_out(d, pv, pt, pg, g);
        chk($sformatf("rst_d%0d_pred_valid", d), pv, 0);
        chk($sformatf("rst_d%0d_ghr", d), g, 0);
      end
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int pv, pt, pg, g;
    n_chk = 0;
    n_err = 0;
    cfg_iw = '{6, 6, 4};
    cfg_cw = '{2, 2, 1};
    cfg_hw = '{6, 6, 1};
    cfg_md = '{0, 1, 1};
    reset = 1'b1;
    do_reset(1'b0);

    // Saturation on bimodal entry 5: 01 -> 10 -> 11 -> 11, then down to 00.
    tbl[0] = '{0, 0, 1, 5, 1, 0, 0, 0};
    tbl[1] = '{0, 0, 1, 5, 1, 0, 0, 0};
    tbl[2] = '{0, 0, 1, 5, 1, 0, 0, 0};
    tbl[3] = '{1, 5, 0, 0, 0, 1, 1, 1};
    tbl[4] = '{0, 0, 1, 5, 0, 0, 1, 1};
    tbl[5] = '{0, 0, 1, 5, 0, 0, 1, 1};
    tbl[6] = '{0, 0, 1, 5, 0, 0, 1, 1};
    tbl[7] = '{0, 0, 1, 5, 0, 0, 1, 1};
    tbl[8] = '{1, 5, 0, 0, 0, 1, 0, 2};
    for (int i = 0; i < 9; i++) begin
      clear_in();
      in_req[0] = tbl[i].req;  in_pidx[0] = tbl[i].pidx;
      in_uv[0]  = tbl[i].uv;   in_uidx[0] = tbl[i].uidx;
      in_ut[0]  = tbl[i].ut;
      step();
      get_out(0, pv, pt, pg, g);
      chk($sformatf("sat%0d_pred_valid", i), pv, tbl[i].e_pv);
      chk($sformatf("sat%0d_pred_taken", i), pt, tbl[i].e_pt);
      chk($sformatf("sat%0d_ghr", i), g, tbl[i].e_ghr);
    end

    do_reset(1'b1);

    // Every entry starts at 01: not-taken now, taken after one taken update.
    for (int i = 0; i < 64; i++) begin
      clear_in(); in_req[0] = 1; in_pidx[0] = i;
      step();
      get_out(0, pv, pt, pg, g);
      chk($sformatf("sweep_init_%0d", i), pt, 0);
    end
    for (int i = 0; i < 64; i++) begin
      clear_in(); in_uv[0] = 1; in_uidx[0] = i; in_ut[0] = 1;
      step();
    end
    for (int i = 0; i < 64; i++) begin
      clear_in(); in_req[0] = 1; in_pidx[0] = i;
      step();
      get_out(0, pv, pt, pg, g);
      chk($sformatf("sweep_one_up_%0d", i), pt, 1);
    end

    do_reset(1'b1);

    // Collision on entry 9: prediction sees the old 01, update still lands.
    clear_in(); in_req[0] = 1; in_pidx[0] = 9; in_uv[0] = 1; in_uidx[0] = 9; in_ut[0] = 1;
    step();
    get_out(0, pv, pt, pg, g);
    chk("collide_old", pt, 0);
    clear_in(); in_req[0] = 1; in_pidx[0] = 9;
    step();
    get_out(0, pv, pt, pg, g);
    chk("collide_new", pt, 1);

    // gshare hashing: train entry 101001, force ghr to 101010 by recovery.
    clear_in(); in_uv[1] = 1; in_uidx[1] = 6'b101001; in_ughr[1] = 0; in_ut[1] = 1;
    step();
    clear_in(); in_uv[1] = 1; in_mis[1] = 1; in_uidx[1] = 0; in_ughr[1] = 6'b010101; in_ut[1] = 0;
    step();
    get_out(1, pv, pt, pg, g);
    chk("hash_setup_ghr", g, 6'b101010);
    clear_in(); in_req[1] = 1; in_pidx[1] = 6'b000011;
    step();
    get_out(1, pv, pt, pg, g);
    chk("hash_pred_valid", pv, 1);
    chk("hash_pred_taken", pt, 1);
    chk("hash_pred_ghr", pg, 6'b101010);
    chk("hash_next_ghr", g, 6'b010101);

    // Recovery beats the speculative shift in the same cycle.
    clear_in(); in_req[1] = 1; in_pidx[1] = 0;
    in_uv[1] = 1; in_mis[1] = 1; in_uidx[1] = 0; in_ughr[1] = 6'b000111; in_ut[1] = 1;
    step();
    get_out(1, pv, pt, pg, g);
    chk("recov_ghr", g, 6'b001111);
    chk("recov_pred_ghr", pg, 6'b010101);
    chk("recov_pred_taken", pt, 0);

    do_reset(1'b1);

    // Random traffic on all three configurations.
    for (int c = 0; c < 3000; c++) begin
      for (int d = 0; d < 3; d++) begin
        in_req[d]  = int'($urandom_range(0, 1));
        in_pidx[d] = int'($urandom_range(0, (1 << cfg_iw[d]) - 1));
        in_uv[d]   = int'($urandom_range(0, 1));
        in_uidx[d] = int'($urandom_range(0, (1 << cfg_iw[d]) - 1));
        in_ughr[d] = int'($urandom_range(0, (1 << cfg_hw[d]) - 1));
        in_ut[d]   = int'($urandom_range(0, 1));
        in_mis[d]  = ($urandom_range(0, 3) == 0) ? 1 : 0;
      end
      step();
      if (c == 1500) do_reset(1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
